// File: rtl/ram_lsu.sv
// Load/store unit in front of a small word RAM: turns byte-addressed requests into
// word accesses, does read-modify-write for sub-word stores and extends load data.
module ram_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_signed,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_resp_rdata,
    output logic                  o_resp_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [1:0]            state_reg, state_next;
    logic                  we_reg;
    logic [1:0]            size_reg;
    logic                  signed_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic [DATA_WIDTH-1:0] word_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  err_reg;

    logic                  req_bad;
    logic                  accept;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_value;
    logic [DATA_WIDTH-1:0] merged;

    assign accept = (state_reg == IDLE) && i_req_valid;

    // Errors are decided from the raw request so they can skip the RAM entirely.
    assign req_bad = (i_req_size == 2'b11)
                   || ((i_req_size == SIZE_HALF) && i_req_addr[0])
                   || ((i_req_size == SIZE_WORD) && (i_req_addr[1:0] != 2'b00))
                   || ((i_req_addr >> 2) >= ADDR_WIDTH'(MEM_WORDS));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_req_valid) begin
                    if (req_bad) begin
                        state_next = RESP;
                    end else if (i_req_we && (i_req_size == SIZE_WORD)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = we_reg ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = i_resp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    // Load lane extraction: move the addressed byte/half down to bit 0, then extend.
    assign shifted = i_mem_data >> {addr_reg[1:0], 3'b000};

    always_comb begin
        case (size_reg)
            SIZE_BYTE: load_value = {{(DATA_WIDTH-8){signed_reg & shifted[7]}}, shifted[7:0]};
            SIZE_HALF: load_value = {{(DATA_WIDTH-16){signed_reg & shifted[15]}}, shifted[15:0]};
            default:   load_value = i_mem_data;
        endcase
    end

    // Store merge: each byte lane takes new data or keeps the word captured in READ.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_src;

            assign lane_hit = (size_reg == SIZE_WORD)
                           || ((size_reg == SIZE_BYTE) && (addr_reg[1:0] == 2'(gi)))
                           || ((size_reg == SIZE_HALF) && (addr_reg[1] == 1'(gi / 2)));
            assign lane_src = (size_reg == SIZE_WORD) ? wdata_reg[8*gi +: 8]
                            : (size_reg == SIZE_HALF) ? wdata_reg[8*(gi % 2) +: 8]
                            : wdata_reg[7:0];
            assign merged[8*gi +: 8] = lane_hit ? lane_src : word_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            we_reg     <= 1'b0;
            size_reg   <= 2'b00;
            signed_reg <= 1'b0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            word_reg   <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                we_reg     <= i_req_we;
                size_reg   <= i_req_size;
                signed_reg <= i_req_signed;
                addr_reg   <= i_req_addr;
                wdata_reg  <= i_req_wdata;
                err_reg    <= req_bad;
                rdata_reg  <= '0;
            end
            if (state_reg == READ) begin
                word_reg <= i_mem_data;
                if (!we_reg) begin
                    rdata_reg <= load_value;
                end
            end
        end
    end

    assign o_req_ready  = (state_reg == IDLE);
    assign o_resp_valid = (state_reg == RESP);
    assign o_resp_err   = (state_reg == RESP) && err_reg;
    assign o_resp_rdata = rdata_reg;
    assign o_mem_addr   = addr_reg >> 2;
    assign o_mem_we     = (state_reg == WRITE);
    assign o_mem_data   = (state_reg == WRITE) ? merged : '0;

endmodule

// File: tb/tb_ram_lsu.sv
// Bench for ram_lsu: a behavioural RAM behind the unit, a directed vector table,
// hand-written stall/reset sequences and randomized traffic against a byte-level model.
module tb_ram_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_addr, mem_data, mem_rdata;
    logic        mem_we;

    int checks = 0;
    int errors = 0;
    int we_total = 0;

    bit [31:0] ram [32];
    bit [31:0] model_mem [32];

    always #5 clk = ~clk;

    ram_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_signed(req_signed), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata), .o_resp_err(resp_err), .o_mem_addr(mem_addr),
        .o_mem_data(mem_data), .o_mem_we(mem_we), .i_mem_data(mem_rdata)
    );

    // The RAM the unit drives: combinational read, clocked write.
    assign mem_rdata = (mem_addr < 32) ? ram[mem_addr[4:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && mem_addr < 32) ram[mem_addr[4:0]] <= mem_data;
    end
    always @(negedge clk) begin
        if (mem_we) we_total <= we_total + 1;
    end

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wes;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: what the request should do, derived byte-by-byte from the rules.
    task automatic model_step(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err,
                              output int lat, output int wes);
        int unsigned idx, off;
        logic [31:0] w, v, mask;
        idx = addr / 4;
        off = addr % 4;
        err = (size == 2'd3) || (size == 2'd1 && off % 2 != 0) ||
              (size == 2'd2 && off != 0) || (addr / 4 >= 32);
        rdata = 0; lat = 1; wes = 0;
        if (err) return;
        w = model_mem[idx[4:0]];
        if (!we) begin
            lat = 2;
            if (size == 2'd0) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (sgn && v >= 128) v = v - 256;
            end else if (size == 2'd1) begin
                v = (w >> (8 * off)) & 32'hFFFF;
                if (sgn && v >= 32768) v = v - 65536;
            end else begin
                v = w;
            end
            rdata = v;
        end else begin
            wes = 1;
            if (size == 2'd2) begin
                lat = 2;
                model_mem[idx[4:0]] = wdata;
            end else begin
                lat = 3;
                mask = (size == 2'd0 ? 32'hFF : 32'hFFFF) << (8 * off);
                model_mem[idx[4:0]] = (w & ~mask) | ((wdata << (8 * off)) & mask);
            end
        end
    endtask

    // Drives one request from a negedge and returns at the negedge after the response handshake.
    task automatic do_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int wes, output logic [31:0] we_addr, output logic [31:0] we_data);
        int guard = 0;
        req_valid = 1; req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        lat = -1; wes = 0; we_addr = 0; we_data = 0;
        for (int k = 1; k <= 10; k++) begin
            if (mem_we) begin
                wes++;
                we_addr = mem_addr;
                we_data = mem_data;
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        rdata = resp_rdata;
        err = resp_err;
        if (lat > 0) begin
            resp_ready = 1;
            @(negedge clk);
            resp_ready = 0;
        end
    endtask

    task automatic run_model_txn(input string tag, input logic we, input logic [1:0] size,
                                 input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat,
                                 output int wes);
        logic [31:0] m_rdata, we_addr, we_data;
        logic        m_err;
        int          m_lat, m_wes;
        model_step(we, size, sgn, addr, wdata, m_rdata, m_err, m_lat, m_wes);
        do_txn(we, size, sgn, addr, wdata, rdata, err, lat, wes, we_addr, we_data);
        $display("%s we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d wes=%0d",
                 tag, we, size, sgn, addr, wdata, rdata, err, lat, wes);
        check({tag, " rdata"}, rdata, m_rdata);
        check({tag, " err"}, 32'(err), 32'(m_err));
        check({tag, " latency"}, lat, m_lat);
        check({tag, " we pulses"}, wes, m_wes);
        if (m_wes == 1) begin
            check({tag, " we addr"}, we_addr, addr / 4);
            check({tag, " we data"}, we_data, model_mem[(addr / 4) % 32]);
        end
    endtask

    initial begin
        logic [31:0] rdata, exp_val, exp_val2;
        logic        err;
        int          lat, wes, we_before, guard;
        logic [31:0] r_addr;
        logic [1:0]  r_size;
        logic        r_we;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
        vecs[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,        1'b0, 2, 1};
        vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AB, 32'h0,        1'b0, 3, 1};
        vecs[4]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h11AB3344, 1'b0, 2, 0};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h8000F0FF, 32'h0,        1'b0, 2, 1};
        vecs[6]  = '{1'b0, 2'd0, 1'b1, 32'h10, 32'h0,        32'hFFFFFFFF, 1'b0, 2, 0};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h000000FF, 1'b0, 2, 0};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFF8000, 1'b0, 2, 0};
        vecs[9]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'h00008000, 1'b0, 2, 0};
        vecs[10] = '{1'b0, 2'd1, 1'b0, 32'h11, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, 32'h0,        1'b1, 1, 0};
        vecs[12] = '{1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1, 1, 0};
        vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h80, 32'h0,        32'h0,        1'b1, 1, 0};

        rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0; resp_ready = 0;
        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        check("reset resp_rdata", resp_rdata, 32'h0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        check("reset mem_addr", mem_addr, 32'h0);
        check("reset mem_data", mem_data, 32'h0);
        rst = 0;
        @(negedge clk);

        // Directed table: hand-derived expectations, model kept in step alongside.
        for (int i = 0; i < 14; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_model_txn(tag, vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr,
                          vecs[i].wdata, rdata, err, lat, wes);
            check({tag, " table rdata"}, rdata, vecs[i].exp_rdata);
            check({tag, " table err"}, 32'(err), 32'(vecs[i].exp_err));
            check({tag, " table latency"}, lat, vecs[i].exp_lat);
            check({tag, " table we pulses"}, wes, vecs[i].exp_wes);
        end
        check("ram word4 after table", ram[4], 32'h8000F0FF);

        // Response stall with a second request held pending behind it.
        exp_val = model_mem[4];
        exp_val2 = model_mem[5];
        req_valid = 1; req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h10;
        @(posedge clk);
        @(negedge clk);
        req_addr = 32'h14;
        guard = 0;
        while (!resp_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("stall response reached", 32'(resp_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            check("stall resp_valid", 32'(resp_valid), 32'd1);
            check("stall rdata", resp_rdata, exp_val);
            check("stall req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        $display("stall load addr=00000010 rdata=%h held 5 cycles", resp_rdata);
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;
        check("stall idle after handshake", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("pending accepted", 32'(req_ready), 32'd0);
        req_valid = 0;
        guard = 0;
        while (!resp_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("pending rdata", resp_rdata, exp_val2);
        $display("pending load addr=00000014 rdata=%h", resp_rdata);
        resp_ready = 1;
        @(negedge clk);
        resp_ready = 0;

        // Reset landing in the READ cycle of a byte store must abort the write.
        we_before = we_total;
        exp_val = model_mem[2];
        req_valid = 1; req_we = 1; req_size = 2'd0; req_signed = 0;
        req_addr = 32'h09; req_wdata = 32'h5A;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        check("rst pre mem_we", 32'(mem_we), 32'd0);
        rst = 1;
        #1;
        check("rst mid req_ready", 32'(req_ready), 32'd1);
        check("rst mid resp_valid", 32'(resp_valid), 32'd0);
        check("rst mid mem_we", 32'(mem_we), 32'd0);
        check("rst mid mem_addr", mem_addr, 32'h0);
        check("rst mid mem_data", mem_data, 32'h0);
        check("rst mid resp_rdata", resp_rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        check("rst released req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("rst no we pulse", we_total, we_before);
        check("rst ram unchanged", ram[2], exp_val);
        $display("reset abort byte store addr=00000009 ram[2]=%h", ram[2]);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            r_we = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = ($urandom_range(0, 9) < 8) ? 32'($urandom_range(0, 131)) : $urandom;
            run_model_txn($sformatf("rnd%0d", n), r_we, r_size, 1'($urandom_range(0, 1)),
                          r_addr, $urandom, rdata, err, lat, wes);
        end
        for (int i = 0; i < 32; i++) begin
            check($sformatf("final ram[%0d]", i), ram[i], model_mem[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
